uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Synthesizable UART receiver; deserialises the asynchronous serial line driven by the bench UART interface or an external device.
- Delivers bytes over a valid/ready stream to the RX FIFO and APB register block of the APB-UART.
- Frame format is runtime-configurable: 5-8 data bits, LSB first; optional even/odd parity; 1 or 2 stop bits.

Parameters:
- DIV_W, 16, width of the clock-cycles-per-bit divider input
- SYNC_STAGES, 2, flip-flop stages on rx_i before use (minimum 2)

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- rx_i  input  1  asynchronous serial line, idle high
- clk_div_i  input  DIV_W  clock cycles per bit; values below 4 are treated as 4
- data_bits_i  input  2  data bit count minus 5 (0=5 … 3=8)
- parity_en_i  input  1  parity bit present
- parity_type_i  input  1  0=even, 1=odd
- extra_stop_i  input  1  second stop bit present
- rx_data_o  output  8  received byte, unused MSBs zero
- rx_valid_o  output  1  rx_data_o holds an unconsumed byte
- rx_ready_i  input  1  consumer accepts byte
- parity_err_o  output  1  parity error flag, qualified by rx_valid_o
- frame_err_o  output  1  stop-bit error flag, qualified by rx_valid_o
- overrun_o  output  1  one-cycle pulse when a completed frame is dropped
- busy_o  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset: state IDLE; rx_data_o=0, rx_valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0, busy_o=0; synchroniser flops preset to 1. Reset mid-frame aborts the frame with no output.
- rx_i passes through SYNC_STAGES flops (rx_s). Falling-edge detect on rx_s: previous sample 1, current sample 0.
- Configuration inputs are latched on the start edge. Changes mid-frame have no effect until the next frame.
- Bit counter counts down from clk_div-1, then reloads; no wrap or overflow beyond DIV_W.
- FSM:
  - IDLE: on falling edge, load counter with clk_div/2 (integer floor) and go to START.
  - START: at expiry, sample rx_s. If rx_s=1 (glitch), return to IDLE with no output. Otherwise reload clk_div and go to DATA.
  - DATA: at each expiry, shift rx_s into bit index i, LSB first. After data_bits samples, go to PARITY if enabled, else STOP.
  - PARITY: sample the bit. Expected value = XOR of data bits, inverted when parity_type=1. Record mismatch.
  - STOP: sample. A 0 records a frame error. If extra_stop is set, go to STOP2; otherwise complete the frame.
  - STOP2: sample. A 0 records a frame error. Complete the frame.
- Completion, same cycle as the final stop sample:
  - If rx_valid_o=0 or rx_ready_i=1 in that cycle: load rx_data_o and error flags, set rx_valid_o=1.
  - Else: drop the frame and pulse overrun_o for 1 cycle.
  - FSM returns to IDLE, so a new start edge in the second half of the stop bit is caught.
- Handshake:
  - rx_valid_o clears the cycle after rx_valid_o & rx_ready_i with no new completion.
  - Completion coincident with acceptance loads the new byte with rx_valid_o staying high.
  - rx_data_o and error flags are stable while valid and not accepted.
- Latency: rx_valid_o rises 1 clock after the mid-point sample of the last stop bit.
- Break (line held 0): the frame completes with data 0 and frame_err_o=1. The FSM then waits in IDLE for a high-to-low edge; no repeated frames while the line stays low.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit decision (start, data, parity, stop) is the 2-of-3 majority of rx_s at counter values 1, 0 and the preceding cycle (three consecutive clocks centred on the mid-point).
- Undefined: single sample at expiry.
- Frame timing and output latency are identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - state enum uart_rx_state_e (IDLE, START, DATA, PARITY, STOP, STOP2)
  - MIN_CLK_DIV = 4
  - parity encoding constants PARITY_EVEN = 0, PARITY_ODD = 1
- One sub-module: uart_bit_sync (SYNC_STAGES synchroniser plus falling-edge detect). Everything else lives in uart_rx_core.

Test Plan:
- clk_div=16, 8N1, bench sends 0xA5 -> rx_data_o=0xA5, both error flags 0, rx_valid_o high 1 clk after stop mid-point.
- 7 bits, odd parity, 2 stop, send 0x5A -> rx_data_o=0x5A; same frame with parity bit flipped -> parity_err_o=1.
- Stop bit forced 0 on 0x3C -> frame_err_o=1, data 0x3C; 20-bit-time break -> one frame, data 0x00, frame_err_o=1, no repeat.
- rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o stays 0x11, overrun_o single pulse; ready asserted in the completion cycle of a third byte 0x33 -> 0x33 loaded, valid stays high.
- Low glitch of clk_div/4 cycles on idle line -> no valid, busy_o returns 0; reset asserted mid-DATA -> all outputs 0, next 0x81 frame received correctly.
- UART_RX_MAJORITY_EN build: single-cycle inverted glitch at every data-bit mid-point of 0xF0 -> 0xF0 received with no errors; same stimulus without macro -> corrupted data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// divider floor, parity encoding and small bit-decision functions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } uart_rx_state_e;

  localparam int MIN_CLK_DIV = 4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Expected parity bit; unused data MSBs must already be zero.
  function automatic logic parity_bit(input logic [7:0] data, input logic parity_type);
    return (^data) ^ (parity_type == PARITY_ODD);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Synchroniser for the asynchronous serial line (flops preset to idle-high)
// plus a falling-edge detector on the synchronised sample.
module uart_bit_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Metastability chain, then one extra flop to spot the 1->0 transition
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_i};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rx_sync_o = sync_r[SYNC_STAGES-1];
  assign fall_o    = prev_r & ~sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 5-8 data bits, optional parity, 1-2 stop bits, valid/ready output.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each bit mid-point.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic [1:0]       data_bits_i,
  input  logic             parity_en_i,
  input  logic             parity_type_i,
  input  logic             extra_stop_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_CLK_DIV);

  logic             rx_s;
  logic             fall_s;
  uart_rx_state_e   state_r, state_nxt_s;
  logic [DIV_W-1:0] cnt_r, cnt_nxt_s, div_r, div_eff_s;
  logic [1:0]       nbits_r;
  logic             par_en_r, par_type_r, stop2_r;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [7:0]       data_r, data_nxt_s;
  logic             perr_r, perr_nxt_s, ferr_r, ferr_nxt_s;
  logic             expire_s, bit_s, done_s;

  uart_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rx_i      (rx_i),
    .rx_sync_o (rx_s),
    .fall_o    (fall_s)
  );

  assign div_eff_s = (clk_div_i < DIV_MIN) ? DIV_MIN : clk_div_i;
  assign expire_s  = (cnt_r == {DIV_W{1'b0}});

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // Two most recent samples before the current one, for the mid-point vote
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rx_s};
    end
  end

  assign bit_s = majority3(hist_r[1], hist_r[0], rx_s);
`else
  assign bit_s = rx_s;
`endif

  // Frame sequencing: one bit decision per counter expiry
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = data_r;
    perr_nxt_s  = perr_r;
    ferr_nxt_s  = ferr_r;
    done_s      = 1'b0;
    if (state_r != IDLE) begin
      cnt_nxt_s = expire_s ? (div_r - CNT_ONE) : (cnt_r - CNT_ONE);
    end else begin
      cnt_nxt_s = cnt_r;
    end
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_nxt_s = START;
          cnt_nxt_s   = div_eff_s >> 1;
          idx_nxt_s   = 3'd0;
          data_nxt_s  = 8'h00;
          perr_nxt_s  = 1'b0;
          ferr_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (expire_s) begin
          state_nxt_s = bit_s ? IDLE : DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (expire_s) begin
          data_nxt_s[idx_r] = bit_s;
          // Last index is 4 + (data bits - 5) = {1, data_bits}
          if (idx_r == {1'b1, nbits_r}) begin
            state_nxt_s = par_en_r ? PARITY : STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (expire_s) begin
          perr_nxt_s  = bit_s ^ parity_bit(data_r, par_type_r);
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (expire_s) begin
          ferr_nxt_s = ferr_r | ~bit_s;
          if (stop2_r) begin
            state_nxt_s = STOP2;
          end else begin
            state_nxt_s = IDLE;
            done_s      = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      STOP2: begin
        if (expire_s) begin
          ferr_nxt_s  = ferr_r | ~bit_s;
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = STOP2;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Frame state, plus configuration captured at the start edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      cnt_r      <= {DIV_W{1'b0}};
      idx_r      <= 3'd0;
      data_r     <= 8'h00;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      div_r      <= DIV_MIN;
      nbits_r    <= 2'd3;
      par_en_r   <= 1'b0;
      par_type_r <= PARITY_EVEN;
      stop2_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      data_r  <= data_nxt_s;
      perr_r  <= perr_nxt_s;
      ferr_r  <= ferr_nxt_s;
      if ((state_r == IDLE) && fall_s) begin
        div_r      <= div_eff_s;
        nbits_r    <= data_bits_i;
        par_en_r   <= parity_en_i;
        par_type_r <= parity_type_i;
        stop2_r    <= extra_stop_i;
      end
    end
  end

  // Output holding register and handshake; a full register drops the new frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o    <= 8'h00;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      busy_o    <= (state_nxt_s != IDLE);
      if (done_s) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= data_r;
          parity_err_o <= perr_r;
          frame_err_o  <= ferr_nxt_s;
          rx_valid_o   <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end else begin
        rx_valid_o <= rx_valid_o;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core; expectations follow the UART_RX_MAJORITY_EN
// setting of the build for the mid-point glitch case.
module tb_uart_rx_core;

  localparam int DIV_W = 16;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'hF0;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h0F;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             rx;
  logic [DIV_W-1:0] clk_div;
  logic [1:0]       data_bits;
  logic             parity_en, parity_type, extra_stop;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_ready;
  logic             parity_err, frame_err, overrun, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int frame_c0 = 0;
  int ovr_cnt = 0;
  logic valid_q = 1'b0;
  logic [9:0] acc_q[$];

  uart_rx_core #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_i          (rx),
    .clk_div_i     (clk_div),
    .data_bits_i   (data_bits),
    .parity_en_i   (parity_en),
    .parity_type_i (parity_type),
    .extra_stop_i  (extra_stop),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .parity_err_o  (parity_err),
    .frame_err_o   (frame_err),
    .overrun_o     (overrun),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled between edges; records accepted bytes as {ferr, perr, data}
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rx_valid && !valid_q) rise_cyc = cyc;
      valid_q = rx_valid;
      if (rx_valid && rx_ready) acc_q.push_back({frame_err, parity_err, rx_data});
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    check_val({tag, "_count"}, 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check_val(tag, 32'(acc_q[0]), 32'(exp));
    acc_q.delete();
  endtask

  // Drive one frame bit-by-bit on negedges; optional data mid-point glitches
  // and a one-cycle ready pulse landing on the completion edge.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop_val, input int nstop,
                            input int div, input logic glitch, input logic ready_at_done);
    logic [11:0] fr;
    int nb, m, done_n;
    logic g;
    fr = 12'hFFF;
    fr[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fr[1+i] = data[i];
    nb = 1 + nbits;
    if (par_en) begin
      fr[nb] = par_bit;
      nb++;
    end
    fr[nb] = stop_val;
    nb = nb + nstop;
    done_n = 4 + div / 2 + div * (nb - 1);
    rise_cyc = -1;
    for (int n = 0; n < nb * div; n++) begin
      @(negedge clk);
      if (n == 0) frame_c0 = cyc;
      m = n - 1 - div / 2;
      g = glitch && (m >= div) && (m % div == 0) && (m / div <= nbits);
      rx = fr[n/div] ^ g;
      if (ready_at_done && (n == done_n - 1)) rx_ready = 1'b1;
      if (ready_at_done && (n == done_n)) rx_ready = 1'b0;
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    clk_div = 16'd16;
    data_bits = 2'd3;
    parity_en = 1'b0;
    parity_type = 1'b0;
    extra_stop = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_data", 32'(rx_data), 32'h0);
    check_val("rst_valid", 32'(rx_valid), 32'h0);
    check_val("rst_perr", 32'(parity_err), 32'h0);
    check_val("rst_ferr", 32'(frame_err), 32'h0);
    check_val("rst_ovr", 32'(overrun), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1, 16, 1'b0, 1'b0);
    check_val("a5_latency", 32'(rise_cyc - frame_c0), 32'd156);
    pop_check("a5", {2'b00, 8'hA5});

    // 7 bits, odd parity, 2 stop bits
    data_bits = 2'd2;
    parity_en = 1'b1;
    parity_type = 1'b1;
    extra_stop = 1'b1;
    send_frame(8'h5A, 7, 1'b1, 1'b1, 1'b1, 2, 16, 1'b0, 1'b0);
    check_val("5a_latency", 32'(rise_cyc - frame_c0), 32'd172);
    pop_check("5a_good", {2'b00, 8'h5A});
    send_frame(8'h5A, 7, 1'b1, 1'b0, 1'b1, 2, 16, 1'b0, 1'b0);
    pop_check("5a_parity_err", {2'b01, 8'h5A});

    // stop bit low, then a 20-bit-time break
    data_bits = 2'd3;
    parity_en = 1'b0;
    parity_type = 1'b0;
    extra_stop = 1'b0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 16, 1'b0, 1'b0);
    pop_check("3c_frame_err", {2'b10, 8'h3C});
    @(negedge clk);
    rx = 1'b0;
    repeat (320) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    pop_check("break", {2'b10, 8'h00});
    check_val("ovr_none", 32'(ovr_cnt), 32'd0);

    // back-pressure and overrun
    rx_ready = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1, 16, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1, 16, 1'b0, 1'b0);
    check_val("ovr_valid", 32'(rx_valid), 32'h1);
    check_val("ovr_data_held", 32'(rx_data), 32'h11);
    check_val("ovr_pulses", 32'(ovr_cnt), 32'd1);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1, 16, 1'b0, 1'b1);
    pop_check("accept_11", {2'b00, 8'h11});
    check_val("swap_valid", 32'(rx_valid), 32'h1);
    check_val("swap_data", 32'(rx_data), 32'h33);
    check_val("swap_ovr", 32'(ovr_cnt), 32'd1);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    pop_check("accept_33", {2'b00, 8'h33});
    check_val("drained_valid", 32'(rx_valid), 32'h0);

    // short low glitch on idle line
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_val("glitch_busy_hi", 32'(busy), 32'h1);
    repeat (40) @(negedge clk);
    check_val("glitch_busy_lo", 32'(busy), 32'h0);
    check_val("glitch_valid", 32'(rx_valid), 32'h0);
    check_val("glitch_nobyte", 32'(acc_q.size()), 32'd0);

    // reset in the middle of the data bits with a byte pending
    rx_ready = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1, 16, 1'b0, 1'b0);
    check_val("pend_data", 32'(rx_data), 32'h55);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    rx = 1'b0;
    repeat (28) @(negedge clk);
    check_val("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mid_rst_outs",
              32'({rx_data, rx_valid, parity_err, frame_err, overrun, busy}), 32'h0);
    rst = 1'b0;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1, 16, 1'b0, 1'b0);
    check_val("81_latency", 32'(rise_cyc - frame_c0), 32'd156);
    pop_check("81", {2'b00, 8'h81});

    // divider below the floor behaves as 4
    clk_div = 16'd2;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1, 4, 1'b0, 1'b0);
    check_val("div4_latency", 32'(rise_cyc - frame_c0), 32'd42);
    pop_check("div4", {2'b00, 8'h96});
    clk_div = 16'd16;

    // one-cycle inverted glitch at each data-bit sample point
    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 1, 16, 1'b1, 1'b0);
    pop_check("midglitch", {2'b00, GLITCH_EXP});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
